// File: rtl/alarm_clock_multi.sv
`default_nettype none
// ============================================================================
// Module      : alarm_clock_multi
// Description : Seconds-of-hour clock with NUM_ALARMS alarm registers, a
//               STOP/RUN/RING/SNOOZE controller and a multiplexed 4-digit
//               BCD display output (sec units, sec tens, min units, min tens).
//               Optional snooze support is built when the macro
//               ALARM_CLOCK_SNOOZE_EN is defined; without it the SNOOZE
//               state and snooze counter do not exist and snooze_button is
//               ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module alarm_clock_multi #(
    parameter int NUM_ALARMS = 4,
    parameter int TICK_DIV   = 50000000,
    parameter int SNOOZE_SEC = 300,
    parameter int RING_SEC   = 60,
    parameter int DIGIT_DIV  = 1000
) (
    input  logic                                                CLK,
    input  logic                                                rst_n,
    input  logic                                                start_stop_button,
    input  logic                                                set_button,
    input  logic                                                snooze_button,
    input  logic [((NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1)-1:0] alarm_sel,
    input  logic [11:0]                                         set_value,
    input  logic [NUM_ALARMS-1:0]                               alarm_en,
    output logic [11:0]                                         time_now,
    output logic [3:0]                                          seven_segment,
    output logic [1:0]                                          digit_sel,
    output logic [NUM_ALARMS-1:0]                               led_out,
    output logic                                                ring
);

    localparam int c_tick_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_dig_w  = (DIGIT_DIV > 1) ? $clog2(DIGIT_DIV) : 1;
    localparam int c_ring_w = (RING_SEC > 0) ? $clog2(RING_SEC + 1) : 1;

    localparam logic [11:0]         c_last_sec  = 12'd3599;
    localparam logic [11:0]         c_sec_limit = 12'd3600;
    localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(TICK_DIV - 1);
    localparam logic [c_tick_w-1:0] c_tick_one  = c_tick_w'(1);
    localparam logic [c_dig_w-1:0]  c_dig_last  = c_dig_w'(DIGIT_DIV - 1);
    localparam logic [c_dig_w-1:0]  c_dig_one   = c_dig_w'(1);
    localparam logic [c_ring_w-1:0] c_ring_load = c_ring_w'(RING_SEC);
    localparam logic [c_ring_w-1:0] c_ring_one  = c_ring_w'(1);

`ifdef ALARM_CLOCK_SNOOZE_EN
    localparam int c_snz_w = (SNOOZE_SEC > 0) ? $clog2(SNOOZE_SEC + 1) : 1;
    localparam logic [c_snz_w-1:0] c_snz_load = c_snz_w'(SNOOZE_SEC);
    localparam logic [c_snz_w-1:0] c_snz_one  = c_snz_w'(1);

    typedef enum logic [1:0] {
        ST_STOP   = 2'd0,
        ST_RUN    = 2'd1,
        ST_RING   = 2'd2,
        ST_SNOOZE = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_RING = 2'd2
    } state_t;
`endif

    state_t                 r_state, w_state_next;
    logic                   r_ss_prev, r_set_prev;
    logic                   w_ss_edge, w_set_edge;
    logic [11:0]            r_time, w_time_next, w_time_inc;
    logic [c_tick_w-1:0]    r_tick_cnt, w_tick_next;
    logic                   w_tick;
    logic [11:0]            r_alarm [NUM_ALARMS];
    logic                   w_alarm_we;
    logic                   w_set_ok, w_sel_ok;
    logic [NUM_ALARMS-1:0]  r_led, w_led_next, w_match;
    logic [c_ring_w-1:0]    r_ring_cnt, w_ring_next;
    logic [c_dig_w-1:0]     r_dig_cnt, w_dig_next;
    logic [1:0]             r_digit_sel, w_digit_next;
    logic [3:0]             r_seg, w_seg_next;

`ifdef ALARM_CLOCK_SNOOZE_EN
    logic                   r_snz_prev;
    logic                   w_snz_edge;
    logic [c_snz_w-1:0]     r_snz_cnt, w_snz_next;

    assign w_snz_edge = snooze_button & ~r_snz_prev;
`else
    logic                   w_unused_snooze;

    assign w_unused_snooze = snooze_button;
`endif

    // BCD digit of a seconds-of-hour value selected by the digit index
    function automatic logic [3:0] f_bcd_digit(input logic [11:0] t, input logic [1:0] d);
        logic [5:0] sec;
        logic [5:0] min;
        sec = 6'(t % 12'd60);
        min = 6'(t / 12'd60);
        case (d)
            2'd0:    f_bcd_digit = 4'(sec % 6'd10);
            2'd1:    f_bcd_digit = 4'(sec / 6'd10);
            2'd2:    f_bcd_digit = 4'(min % 6'd10);
            default: f_bcd_digit = 4'(min / 6'd10);
        endcase
    endfunction

    assign w_ss_edge  = start_stop_button & ~r_ss_prev;
    assign w_set_edge = set_button & ~r_set_prev;
    assign w_tick     = (r_state != ST_STOP) && (r_tick_cnt == c_tick_last);
    assign w_time_inc = (r_time >= c_last_sec) ? 12'd0 : r_time + 12'd1;
    assign w_set_ok   = (set_value < c_sec_limit);
    assign w_sel_ok   = (int'(alarm_sel) < NUM_ALARMS);

    // Alarms compare against the time value being entered on this tick
    genvar gi;
    for (gi = 0; gi < NUM_ALARMS; gi++) begin : g_match
        assign w_match[gi] = w_tick & alarm_en[gi] & (r_alarm[gi] == w_time_inc);
    end

    // Next-state and datapath-next logic for the controller
    always_comb begin
        w_state_next = r_state;
        w_time_next  = w_tick ? w_time_inc : r_time;
        w_tick_next  = (r_state == ST_STOP) ? r_tick_cnt
                     : (w_tick ? '0 : r_tick_cnt + c_tick_one);
        w_led_next   = r_led | w_match;
        w_ring_next  = r_ring_cnt;
        w_alarm_we   = 1'b0;
`ifdef ALARM_CLOCK_SNOOZE_EN
        w_snz_next   = r_snz_cnt;
`endif
        case (r_state)
            ST_STOP: begin
                if (w_ss_edge) begin
                    w_state_next = ST_RUN;
                end else if (w_set_edge && w_set_ok) begin
                    w_time_next = set_value;
                    w_tick_next = '0;
                end
            end
            ST_RUN: begin
                if (w_ss_edge) begin
                    w_state_next = ST_STOP;
                end else begin
                    w_alarm_we = w_set_edge & w_set_ok & w_sel_ok;
                    if (|w_match) begin
                        w_state_next = ST_RING;
                        w_ring_next  = c_ring_load;
                    end
                end
            end
            ST_RING: begin
                if (w_ss_edge) begin
                    w_state_next = ST_RUN;
                    w_led_next   = '0;
`ifdef ALARM_CLOCK_SNOOZE_EN
                end else if (w_snz_edge) begin
                    w_state_next = ST_SNOOZE;
                    w_snz_next   = c_snz_load;
`endif
                end else begin
                    w_alarm_we = w_set_edge & w_set_ok & w_sel_ok;
                    if (w_tick) begin
                        // Unattended ring times out on the tick that consumes its last second
                        if (r_ring_cnt <= c_ring_one) begin
                            w_state_next = ST_RUN;
                            w_led_next   = '0;
                        end else begin
                            w_ring_next = r_ring_cnt - c_ring_one;
                        end
                    end
                end
            end
`ifdef ALARM_CLOCK_SNOOZE_EN
            ST_SNOOZE: begin
                if (w_ss_edge) begin
                    w_state_next = ST_RUN;
                    w_led_next   = '0;
                end else begin
                    w_alarm_we = w_set_edge & w_set_ok & w_sel_ok;
                    if (|w_match) begin
                        w_state_next = ST_RING;
                        w_ring_next  = c_ring_load;
                    end else if (w_tick) begin
                        if (r_snz_cnt <= c_snz_one) begin
                            w_state_next = ST_RING;
                            w_ring_next  = c_ring_load;
                        end else begin
                            w_snz_next = r_snz_cnt - c_snz_one;
                        end
                    end
                end
            end
`endif
            default: begin
                w_state_next = ST_STOP;
            end
        endcase
    end

    // Display scan: digit index steps every DIGIT_DIV cycles, segment value tracks it
    always_comb begin
        w_dig_next   = (r_dig_cnt == c_dig_last) ? '0 : r_dig_cnt + c_dig_one;
        w_digit_next = (r_dig_cnt == c_dig_last) ? r_digit_sel + 2'd1 : r_digit_sel;
        w_seg_next   = f_bcd_digit(w_time_next, w_digit_next);
    end

    // Controller, timekeeping and display registers
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            r_state     <= ST_STOP;
            r_ss_prev   <= 1'b1;
            r_set_prev  <= 1'b1;
            r_time      <= '0;
            r_tick_cnt  <= '0;
            r_led       <= '0;
            r_ring_cnt  <= '0;
            r_dig_cnt   <= '0;
            r_digit_sel <= '0;
            r_seg       <= '0;
`ifdef ALARM_CLOCK_SNOOZE_EN
            r_snz_prev  <= 1'b1;
            r_snz_cnt   <= '0;
`endif
        end else begin
            r_state     <= w_state_next;
            r_ss_prev   <= start_stop_button;
            r_set_prev  <= set_button;
            r_time      <= w_time_next;
            r_tick_cnt  <= w_tick_next;
            r_led       <= w_led_next;
            r_ring_cnt  <= w_ring_next;
            r_dig_cnt   <= w_dig_next;
            r_digit_sel <= w_digit_next;
            r_seg       <= w_seg_next;
`ifdef ALARM_CLOCK_SNOOZE_EN
            r_snz_prev  <= snooze_button;
            r_snz_cnt   <= w_snz_next;
`endif
        end
    end

    // Alarm register file, written by set while the clock is running
    always_ff @(posedge CLK) begin
        for (int i = 0; i < NUM_ALARMS; i++) begin
            if (!rst_n) begin
                r_alarm[i] <= '0;
            end else if (w_alarm_we && (int'(alarm_sel) == i)) begin
                r_alarm[i] <= set_value;
            end
        end
    end

    assign time_now      = r_time;
    assign seven_segment = r_seg;
    assign digit_sel     = r_digit_sel;
    assign led_out       = r_led;
    assign ring          = (r_state == ST_RING);

endmodule
`default_nettype wire

// File: tb/tb_alarm_clock_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_alarm_clock_multi
// Description : Self-checking bench for alarm_clock_multi with a behavioural
//               reference model; directed scenarios then randomized buttons.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alarm_clock_multi;

    localparam int c_num_alarms = 2;
    localparam int c_tick_div   = 4;
    localparam int c_snooze_sec = 3;
    localparam int c_ring_sec   = 5;
    localparam int c_digit_div  = 2;
`ifdef ALARM_CLOCK_SNOOZE_EN
    localparam bit c_snz = 1'b1;
`else
    localparam bit c_snz = 1'b0;
`endif

    localparam int M_STOP   = 0;
    localparam int M_RUN    = 1;
    localparam int M_RING   = 2;
    localparam int M_SNOOZE = 3;

    logic        CLK = 1'b0;
    logic        rst_n;
    logic        start_stop_button, set_button, snooze_button;
    logic [0:0]  alarm_sel;
    logic [11:0] set_value;
    logic [1:0]  alarm_en;
    logic [11:0] time_now;
    logic [3:0]  seven_segment;
    logic [1:0]  digit_sel;
    logic [1:0]  led_out;
    logic        ring;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int m_mode, m_time, m_ph, m_led, m_ring_left, m_snz_left, m_dcyc;
    int m_alarm [c_num_alarms];
    bit m_pss, m_pst, m_psz;

    alarm_clock_multi #(
        .NUM_ALARMS (c_num_alarms),
        .TICK_DIV   (c_tick_div),
        .SNOOZE_SEC (c_snooze_sec),
        .RING_SEC   (c_ring_sec),
        .DIGIT_DIV  (c_digit_div)
    ) dut (
        .CLK               (CLK),
        .rst_n             (rst_n),
        .start_stop_button (start_stop_button),
        .set_button        (set_button),
        .snooze_button     (snooze_button),
        .alarm_sel         (alarm_sel),
        .set_value         (set_value),
        .alarm_en          (alarm_en),
        .time_now          (time_now),
        .seven_segment     (seven_segment),
        .digit_sel         (digit_sel),
        .led_out           (led_out),
        .ring              (ring)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int digit_of(input int t, input int d);
        int s, m;
        s = t % 60;
        m = t / 60;
        case (d)
            0:       return s % 10;
            1:       return s / 10;
            2:       return m % 10;
            default: return m / 10;
        endcase
    endfunction

    // Behavioural clock: one call per rising edge, using the inputs seen at that edge
    task automatic model_step();
        bit e_ss, e_st, e_sz, tick, ok;
        int nt, nph, nled, nmode, hits;
        if (!rst_n) begin
            m_mode = M_STOP; m_time = 0; m_ph = 0; m_led = 0;
            m_ring_left = 0; m_snz_left = 0; m_dcyc = 0;
            for (int i = 0; i < c_num_alarms; i++) m_alarm[i] = 0;
            m_pss = 1'b1; m_pst = 1'b1; m_psz = 1'b1;
        end else begin
            e_ss = start_stop_button && !m_pss;
            e_st = set_button && !m_pst;
            e_sz = snooze_button && !m_psz && c_snz;
            m_pss = start_stop_button; m_pst = set_button; m_psz = snooze_button;
            ok    = (set_value < 3600);
            tick  = (m_mode != M_STOP) && (m_ph == c_tick_div - 1);
            nt    = tick ? (m_time + 1) % 3600 : m_time;
            nph   = (m_mode != M_STOP) ? (m_ph + 1) % c_tick_div : m_ph;
            hits  = 0;
            for (int i = 0; i < c_num_alarms; i++)
                if (tick && alarm_en[i] && m_alarm[i] == nt) hits |= (1 << i);
            nled  = m_led | hits;
            nmode = m_mode;
            case (m_mode)
                M_STOP: begin
                    if (e_ss) nmode = M_RUN;
                    else if (e_st && ok) begin nt = set_value; nph = 0; end
                end
                M_RUN: begin
                    if (e_ss) nmode = M_STOP;
                    else begin
                        if (e_st && ok) m_alarm[int'(alarm_sel)] = set_value;
                        if (hits != 0) begin nmode = M_RING; m_ring_left = c_ring_sec; end
                    end
                end
                M_RING: begin
                    if (e_ss) begin nmode = M_RUN; nled = 0; end
                    else if (e_sz) begin nmode = M_SNOOZE; m_snz_left = c_snooze_sec; end
                    else begin
                        if (e_st && ok) m_alarm[int'(alarm_sel)] = set_value;
                        if (tick) begin
                            m_ring_left--;
                            if (m_ring_left <= 0) begin nmode = M_RUN; nled = 0; end
                        end
                    end
                end
                default: begin
                    if (e_ss) begin nmode = M_RUN; nled = 0; end
                    else begin
                        if (e_st && ok) m_alarm[int'(alarm_sel)] = set_value;
                        if (hits != 0) begin nmode = M_RING; m_ring_left = c_ring_sec; end
                        else if (tick) begin
                            m_snz_left--;
                            if (m_snz_left <= 0) begin nmode = M_RING; m_ring_left = c_ring_sec; end
                        end
                    end
                end
            endcase
            m_time = nt; m_ph = nph; m_led = nled; m_mode = nmode;
            m_dcyc++;
        end
    endtask

    task automatic compare_all();
        int d;
        d = (m_dcyc / c_digit_div) % 4;
        check("time_now", time_now, m_time);
        check("led_out", led_out, m_led);
        check("ring", ring, (m_mode == M_RING));
        check("digit_sel", digit_sel, d);
        check("seven_segment", seven_segment, digit_of(m_time, d));
    endtask

    task automatic cycle();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
        compare_all();
    endtask

    // which: 0 start_stop, 1 set, 2 snooze
    task automatic press(input int which);
        case (which)
            0:       start_stop_button = 1'b1;
            1:       set_button = 1'b1;
            default: snooze_button = 1'b1;
        endcase
        cycle();
        start_stop_button = 1'b0; set_button = 1'b0; snooze_button = 1'b0;
        cycle();
    endtask

    task automatic wait_time(input int t, input int budget);
        int n;
        n = 0;
        while (time_now !== 12'(t) && n < budget) begin
            cycle();
            n++;
        end
        check("wait_time", time_now, t);
    endtask

    initial begin
        int t0;
        rst_n = 1'b0; start_stop_button = 1'b1; set_button = 1'b0; snooze_button = 1'b0;
        alarm_sel = 1'b0; set_value = 12'd0; alarm_en = 2'b00;
        repeat (3) cycle();
        check("rst_time", time_now, 0);
        check("rst_led", led_out, 0);
        check("rst_ring", ring, 0);
        check("rst_digit", digit_sel, 0);
        check("rst_seg", seven_segment, 0);

        // Button held through reset release must not start the clock
        rst_n = 1'b1;
        repeat (8) cycle();
        check("held_button_no_start", time_now, 0);
        start_stop_button = 1'b0;
        cycle();

        // Load 3599 in STOP, start, wrap to 0 after one second
        set_value = 12'd3599;
        set_button = 1'b1; cycle(); set_button = 1'b0;
        check("load_3599", time_now, 3599);
        cycle();
        start_stop_button = 1'b1; cycle(); start_stop_button = 1'b0;
        check("start_3599", time_now, 3599);
        repeat (3) cycle();
        check("before_wrap", time_now, 3599);
        cycle();
        check("wrap_to_0", time_now, 0);

        // Alarm 0 at 10, starting from 8, ring timeout at 15
        press(0);
        set_value = 12'd8; press(1);
        check("load_8", time_now, 8);
        alarm_en = 2'b01;
        press(0);
        alarm_sel = 1'b0; set_value = 12'd10; press(1);
        wait_time(10, 40);
        check("ring_at_10", ring, 1);
        check("led_at_10", led_out, 2'b01);
        wait_time(15, 40);
        check("timeout_ring", ring, 0);
        check("timeout_led", led_out, 2'b00);

        // start_stop and snooze on the same edge while ringing
        alarm_sel = 1'b1; set_value = 12'd18; alarm_en = 2'b11; press(1);
        wait_time(18, 40);
        check("ring_at_18", ring, 1);
        check("led_at_18", led_out, 2'b10);
        start_stop_button = 1'b1; snooze_button = 1'b1; cycle();
        start_stop_button = 1'b0; snooze_button = 1'b0;
        check("both_ring", ring, 0);
        check("both_led", led_out, 0);
        t0 = int'(time_now);
        repeat (8) cycle();
        check("keeps_counting", time_now, t0 + 2);

        // Snooze pressed while ringing
        alarm_sel = 1'b1; set_value = 12'd25; press(1);
        wait_time(25, 60);
        check("ring_at_25", ring, 1);
        wait_time(26, 8);
        snooze_button = 1'b1; cycle(); snooze_button = 1'b0; cycle();
`ifdef ALARM_CLOCK_SNOOZE_EN
        check("snooze_ring", ring, 0);
        check("snooze_led", led_out, 2'b10);
        wait_time(29, 16);
        check("resnooze_ring", ring, 1);
        press(0);
        press(0);
`else
        check("snooze_ignored", ring, 1);
        wait_time(29, 16);
        check("still_ringing", ring, 1);
        wait_time(30, 8);
        check("timeout_after_snooze", ring, 0);
        check("timeout_after_snooze_led", led_out, 0);
        press(0);
`endif

        // Out-of-range set values are ignored
        t0 = int'(time_now);
        set_value = 12'd4000; press(1);
        check("ignore_big_time", time_now, t0);
        set_value = 12'd38; press(1);
        check("load_38", time_now, 38);
        press(0);
        alarm_sel = 1'b0; set_value = 12'd40; press(1);
        alarm_sel = 1'b1; set_value = 12'd40; press(1);
        wait_time(40, 40);
        check("dual_led", led_out, 2'b11);
        check("dual_ring", ring, 1);
        alarm_sel = 1'b0; set_value = 12'd4000; press(1);
        press(0);
        check("cleared_led", led_out, 0);
        press(0);
        set_value = 12'd38; press(1);
        press(0);
        wait_time(40, 40);
        check("alarms_kept_after_bad_set", led_out, 2'b11);

        // Reset in the middle of a ring aborts to STOP
        rst_n = 1'b0; cycle(); rst_n = 1'b1;
        check("abort_ring", ring, 0);
        check("abort_time", time_now, 0);
        check("abort_led", led_out, 0);
        repeat (8) cycle();
        check("abort_stopped", time_now, 0);

        // Randomized button activity
        for (int k = 0; k < 1500; k++) begin
            rst_n             = ($urandom_range(0, 299) != 0);
            start_stop_button = ($urandom_range(0, 29) == 0);
            set_button        = ($urandom_range(0, 5) == 0);
            snooze_button     = ($urandom_range(0, 9) == 0);
            alarm_sel         = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) set_value = 12'($urandom_range(3600, 4095));
            else set_value = 12'((m_time + int'($urandom_range(0, 6))) % 3600);
            if ($urandom_range(0, 49) == 0) alarm_en = 2'($urandom_range(0, 3));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
